// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the word-addressed fetch stage: advance, stall,
// redirect with flush bubbles, halt/resume, plus saturating debug counters.
module fetch_sequencer #(
    parameter int          ADDR_W       = 8,
    parameter logic [31:0] RESET_PC     = 32'd0,
    parameter int          FLUSH_CYCLES = 1,
    parameter int          CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    input  logic             halt_req,
    output logic [31:0]      pc,
    output logic [31:0]      npc,
    output logic             fetch_en,
    output logic             flush,
    output logic             halted,
    output logic             addr_err,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;

    localparam logic [3:0]        FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [ADDR_W-1:0] PC_INIT      = RESET_PC[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] PC_ONE       = 1;
    localparam logic [CNT_W-1:0]  CNT_ONE      = 1;

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_inc;
    logic [3:0]        flush_cnt;
    logic              redirect;
    logic              tgt_high;
    logic              stall_hold;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign pc_inc     = pc_q + PC_ONE;
    assign pc         = {{(32-ADDR_W){1'b0}}, pc_q};
    assign npc        = {{(32-ADDR_W){1'b0}}, pc_inc};
    assign redirect   = br_taken && (state == RUN || state == FLUSH);
    assign tgt_high   = |(br_target >> ADDR_W);
    assign fetch_en   = (state == RUN) && !stall && !br_taken && !halt_req;
    assign stall_hold = (state == RUN) && stall && !br_taken && !halt_req;
    assign flush      = ((state == RUN) && br_taken) || (state == FLUSH);
    assign halted     = (state == HALT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            pc_q      <= PC_INIT;
            flush_cnt <= 4'd0;
            addr_err  <= 1'b0;
            instr_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (fetch_en)
                instr_cnt <= sat_inc(instr_cnt);
            if (stall_hold)
                stall_cnt <= sat_inc(stall_cnt);
            // Out-of-range targets are still taken (truncated), only flagged.
            if (redirect && tgt_high)
                addr_err <= 1'b1;
            case (state)
                IDLE: if (start) state <= RUN;
                RUN: begin
                    if (br_taken) begin
                        pc_q      <= br_target[ADDR_W-1:0];
                        flush_cnt <= FLUSH_RELOAD;
                        state     <= (FLUSH_RELOAD != 4'd0) ? FLUSH : RUN;
                    end else if (halt_req) begin
                        state <= HALT;
                    end else if (!stall) begin
                        pc_q <= pc_inc;
                    end
                end
                FLUSH: begin
                    // A newer redirect restarts the bubble window at its own target.
                    if (br_taken) begin
                        pc_q      <= br_target[ADDR_W-1:0];
                        flush_cnt <= FLUSH_RELOAD;
                        state     <= (FLUSH_RELOAD != 4'd0) ? FLUSH : RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                        if (flush_cnt == 4'd1)
                            state <= RUN;
                    end
                end
                HALT: if (start) state <= RUN;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_fetch_sequencer;

    localparam int ADDR_W = 8;
    localparam int FC     = 2;
    localparam int CNT_W  = 8;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CMAX   = (1 << CNT_W) - 1;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_FLUSH = 2;
    localparam int M_HALT  = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0, stall = 1'b0, br_taken = 1'b0, halt_req = 1'b0;
    logic [31:0]      br_target = 32'd0;
    logic [31:0]      pc, npc;
    logic             fetch_en, flush, halted, addr_err;
    logic [CNT_W-1:0] instr_cnt, stall_cnt;

    int checks = 0;
    int errors = 0;

    int m_mode, m_pc, m_bubbles, m_icnt, m_scnt;
    bit m_err;

    fetch_sequencer #(
        .ADDR_W(ADDR_W), .RESET_PC(32'd0), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .halt_req(halt_req), .pc(pc), .npc(npc),
        .fetch_en(fetch_en), .flush(flush), .halted(halted), .addr_err(addr_err),
        .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_pc = 0; m_bubbles = 0; m_icnt = 0; m_scnt = 0; m_err = 0;
    endtask

    task automatic model_redirect();
        m_pc = br_target % DEPTH;
        if ((br_target >> ADDR_W) != 0) m_err = 1;
        m_bubbles = FC - 1;
        m_mode = (m_bubbles > 0) ? M_FLUSH : M_RUN;
    endtask

    task automatic model_step();
        case (m_mode)
            M_IDLE: if (start) m_mode = M_RUN;
            M_RUN: begin
                if (br_taken) model_redirect();
                else if (halt_req) m_mode = M_HALT;
                else if (stall) m_scnt = (m_scnt < CMAX) ? m_scnt + 1 : CMAX;
                else begin
                    m_pc = (m_pc + 1) % DEPTH;
                    m_icnt = (m_icnt < CMAX) ? m_icnt + 1 : CMAX;
                end
            end
            M_FLUSH: begin
                if (br_taken) model_redirect();
                else begin
                    m_bubbles--;
                    if (m_bubbles == 0) m_mode = M_RUN;
                end
            end
            default: if (start) m_mode = M_RUN;
        endcase
    endtask

    task automatic compare_all();
        bit exp_fetch;
        exp_fetch = (m_mode == M_RUN) && !stall && !br_taken && !halt_req;
        chk("pc", pc, m_pc);
        chk("npc", npc, (m_pc + 1) % DEPTH);
        chk("fetch_en", fetch_en, exp_fetch);
        chk("flush", flush, (m_mode == M_FLUSH) || (m_mode == M_RUN && br_taken));
        chk("halted", halted, m_mode == M_HALT);
        chk("addr_err", addr_err, m_err);
        chk("instr_cnt", instr_cnt, m_icnt);
        chk("stall_cnt", stall_cnt, m_scnt);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            model_reset();
            compare_all();
        end else begin
            compare_all();
            model_step();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sp, bp, hp;
        repeat (3) step();
        #1 chk("rst_pc", pc, 0);
        chk("rst_npc", npc, 1);
        rst = 1'b1;

        // start, then four free-running fetches
        step(); start = 1'b1;
        #1 chk("idle_fetch", fetch_en, 0);
        step(); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("run_pc", pc, i);
            chk("run_fetch", fetch_en, 1);
            step();
        end

        // stall three cycles
        stall = 1'b1;
        #1 chk("pc_after4", pc, 4);
        chk("instr4", instr_cnt, 4);
        chk("stall_fetch", fetch_en, 0);
        step();
        repeat (2) begin
            #1 chk("stall_pc", pc, 4);
            chk("stall_fetch", fetch_en, 0);
            step();
        end
        stall = 1'b0;
        #1 chk("stall_cnt3", stall_cnt, 3);
        chk("resume_fetch", fetch_en, 1);
        step();
        #1 chk("pc_after_stall", pc, 5);

        // asynchronous reset mid-run, no clock edge needed
        rst = 1'b0;
        #1 chk("arst_pc", pc, 0);
        chk("arst_instr", instr_cnt, 0);
        chk("arst_stall", stall_cnt, 0);
        chk("arst_fetch", fetch_en, 0);
        step(); rst = 1'b1;
        step(); start = 1'b1;
        step(); start = 1'b0;
        step(); step();

        // redirect with simultaneous stall, two flush cycles
        br_taken = 1'b1; stall = 1'b1; br_target = 32'h40;
        #1 chk("br_flush0", flush, 1);
        chk("br_fetch0", fetch_en, 0);
        chk("br_pc0", pc, 2);
        step(); br_taken = 1'b0; stall = 1'b0;
        #1 chk("br_flush1", flush, 1);
        chk("br_fetch1", fetch_en, 0);
        chk("br_pc1", pc, 32'h40);
        step();
        #1 chk("br_flush2", flush, 0);
        chk("br_fetch2", fetch_en, 1);
        chk("br_pc2", pc, 32'h40);
        step();
        #1 chk("br_pc3", pc, 32'h41);

        // wrap at top of memory, then out-of-range target
        br_taken = 1'b1; br_target = 32'hFF;
        step(); br_taken = 1'b0;
        step();
        #1 chk("top_pc", pc, 32'hFF);
        chk("top_npc", npc, 0);
        chk("top_fetch", fetch_en, 1);
        step();
        #1 chk("wrap_pc", pc, 0);
        chk("err_clear", addr_err, 0);
        br_taken = 1'b1; br_target = 32'h0001_0010;
        step(); br_taken = 1'b0;
        #1 chk("trunc_pc", pc, 32'h10);
        chk("err_set", addr_err, 1);
        step(); step();
        #1 chk("err_sticky", addr_err, 1);

        // halt holds pc through redirects and stalls, start resumes
        br_taken = 1'b1; br_target = 32'h7;
        step(); br_taken = 1'b0;
        step();
        halt_req = 1'b1;
        #1 chk("halt_req_fetch", fetch_en, 0);
        chk("halt_req_pc", pc, 7);
        step(); halt_req = 1'b0; br_taken = 1'b1; br_target = 32'h33; stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("halt_flag", halted, 1);
            chk("halt_pc", pc, 7);
            chk("halt_fetch", fetch_en, 0);
            step();
        end
        br_taken = 1'b0; stall = 1'b0; start = 1'b1;
        #1 chk("halt_flag_start", halted, 1);
        step(); start = 1'b0;
        #1 chk("resume_pc", pc, 7);
        chk("resume_fetch7", fetch_en, 1);
        chk("resume_halted", halted, 0);
        step();
        #1 chk("resume_pc8", pc, 8);

        // instruction counter saturation
        rst = 1'b0;
        step(); rst = 1'b1;
        step(); start = 1'b1;
        step(); start = 1'b0;
        repeat (300) step();
        #1 chk("instr_sat", instr_cnt, CMAX);

        // randomized traffic, checked by the per-cycle compare process
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c < 1500)      begin sp = 25; bp = 10; hp = 4; end
            else if (c < 2200) begin sp = 80; bp = 4;  hp = 2; end
            else               begin sp = 5;  bp = 5;  hp = 2; end
            rst       = !(c < 1500 && $urandom_range(299) == 0);
            start     = ($urandom_range(99) < 40);
            stall     = ($urandom_range(99) < sp);
            br_taken  = ($urandom_range(99) < bp);
            halt_req  = ($urandom_range(99) < hp);
            br_target = ($urandom_range(9) == 0) ? $urandom : 32'($urandom_range(DEPTH - 1));
        end
        step();
        rst = 1'b1; start = 1'b0; stall = 1'b0; br_taken = 1'b0; halt_req = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
